// File: rtl/thresholding_lane_regroup.sv
// Regroups IN_PE-element beats from the thresholding kernel into OUT_PE-element beats (up, down or pass-through).
// Define THRESHOLDING_LANE_REGROUP_TLAST_EN to build the frame counter that drives output_tlast.
module thresholding_lane_regroup #(
  parameter int IN_PE      = 1,
  parameter int OUT_PE     = 1,
  parameter int ELEM_WIDTH = 8,
  parameter int CHANNELS   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   input_tready,
  input  logic                                   input_tvalid,
  input  logic [((IN_PE*ELEM_WIDTH+7)/8)*8-1:0]  input_tdata,
  input  logic                                   output_tready,
  output logic                                   output_tvalid,
  output logic [((OUT_PE*ELEM_WIDTH+7)/8)*8-1:0] output_tdata,
  output logic                                   output_tlast
);

  localparam int IN_EW  = IN_PE * ELEM_WIDTH;
  localparam int OUT_EW = OUT_PE * ELEM_WIDTH;
  localparam int MAX_PE = (IN_PE > OUT_PE) ? IN_PE : OUT_PE;
  localparam int MIN_PE = (IN_PE > OUT_PE) ? OUT_PE : IN_PE;
  localparam int R      = MAX_PE / MIN_PE;

  generate
    if ((MAX_PE % MIN_PE) != 0) begin : g_bad_pe
      $error("thresholding_lane_regroup: IN_PE and OUT_PE must divide one another");
    end
    if (((CHANNELS % IN_PE) != 0) || ((CHANNELS % OUT_PE) != 0)) begin : g_bad_channels
      $error("thresholding_lane_regroup: CHANNELS must be a multiple of IN_PE and OUT_PE");
    end
  endgenerate

  logic [IN_EW-1:0]  in_lanes;
  logic [OUT_EW-1:0] out_lanes;
  logic              out_valid;
  logic              in_accept;
  logic              out_accept;
  logic              unused_in_pad;

  assign in_lanes      = input_tdata[IN_EW-1:0];
  assign unused_in_pad = ^input_tdata;
  assign in_accept     = input_tvalid && input_tready;
  assign out_accept    = out_valid && output_tready;
  assign output_tvalid = out_valid;

  always_comb begin
    output_tdata               = '0;
    output_tdata[OUT_EW-1:0]   = out_lanes;
  end

  generate
    if (R == 1) begin : g_pass
      logic [OUT_EW-1:0] out_reg;

      assign input_tready = !rst && (!out_valid || output_tready);
      assign out_lanes    = out_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_reg   <= '0;
          out_valid <= 1'b0;
        end else if (in_accept) begin
          out_reg   <= in_lanes;
          out_valid <= 1'b1;
        end else if (out_accept) begin
          out_valid <= 1'b0;
        end
      end
    end else if (OUT_PE > IN_PE) begin : g_up
      localparam int CW = $clog2(R);
      // Only the first R-1 slots are stored; the last beat is merged straight into the output register.
      logic [(R-1)*IN_EW-1:0] acc;
      logic [CW-1:0]          k;
      logic [OUT_EW-1:0]      out_reg;
      logic                   last_slot;

      assign last_slot    = (k == CW'(R-1));
      assign input_tready = !rst && (!last_slot || !out_valid || output_tready);
      assign out_lanes    = out_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          acc       <= '0;
          k         <= '0;
          out_reg   <= '0;
          out_valid <= 1'b0;
        end else begin
          if (out_accept) begin
            out_valid <= 1'b0;
          end
          if (in_accept) begin
            if (last_slot) begin
              out_reg   <= {in_lanes, acc};
              out_valid <= 1'b1;
              k         <= '0;
            end else begin
              acc[k*IN_EW +: IN_EW] <= in_lanes;
              k                     <= k + CW'(1);
            end
          end
        end
      end
    end else begin : g_down
      localparam int CW = $clog2(R);
      logic [IN_EW-1:0] held;
      logic [CW-1:0]    s;
      logic             last_slice;

      assign last_slice   = (s == CW'(R-1));
      assign input_tready = !rst && (!out_valid || (output_tready && last_slice));
      assign out_lanes    = held[s*OUT_EW +: OUT_EW];

      // A new word may land in the same cycle the final slice leaves, so the accept branch wins.
      always_ff @(posedge clk) begin
        if (rst) begin
          held      <= '0;
          s         <= '0;
          out_valid <= 1'b0;
        end else if (in_accept) begin
          held      <= in_lanes;
          s         <= '0;
          out_valid <= 1'b1;
        end else if (out_accept) begin
          if (last_slice) begin
            s         <= '0;
            out_valid <= 1'b0;
          end else begin
            s <= s + CW'(1);
          end
        end
      end
    end
  endgenerate

`ifdef THRESHOLDING_LANE_REGROUP_TLAST_EN
  localparam int FB = CHANNELS / OUT_PE;
  localparam int FW = (FB > 1) ? $clog2(FB) : 1;
  logic [FW-1:0] f;

  always_ff @(posedge clk) begin
    if (rst) begin
      f <= '0;
    end else if (out_accept) begin
      f <= (f == FW'(FB-1)) ? '0 : f + FW'(1);
    end
  end

  assign output_tlast = out_valid && (f == FW'(FB-1));
`else
  assign output_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_thresholding_lane_regroup.sv
// Scoreboard bench for thresholding_lane_regroup: four instances (up, down, padded down, pass-through)
// fed with directed vectors; per-instance monitors pop hand-computed expectations on every output transfer.
module tb_thresholding_lane_regroup;

`ifdef THRESHOLDING_LANE_REGROUP_TLAST_EN
  localparam bit TLAST_ON = 1'b1;
`else
  localparam bit TLAST_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;

  logic        up_in_ready, up_in_valid, up_out_ready, up_out_valid, up_out_last;
  logic [7:0]  up_in_data;
  logic [15:0] up_out_data;

  logic        dn_in_ready, dn_in_valid, dn_out_ready, dn_out_valid, dn_out_last;
  logic [31:0] dn_in_data;
  logic [7:0]  dn_out_data;

  logic        pd_in_ready, pd_in_valid, pd_out_ready, pd_out_valid, pd_out_last;
  logic [15:0] pd_in_data;
  logic [7:0]  pd_out_data;

  logic        ps_in_ready, ps_in_valid, ps_out_ready, ps_out_valid, ps_out_last;
  logic [15:0] ps_in_data;
  logic [15:0] ps_out_data;

  int   total;
  int   bad;
  int   push_cnt [4];
  exp_t q_up[$];
  exp_t q_dn[$];
  exp_t q_pd[$];
  exp_t q_ps[$];

  thresholding_lane_regroup #(.IN_PE(2), .OUT_PE(4), .ELEM_WIDTH(4), .CHANNELS(8)) u_up (
    .clk(clk), .rst(rst),
    .input_tready(up_in_ready), .input_tvalid(up_in_valid), .input_tdata(up_in_data),
    .output_tready(up_out_ready), .output_tvalid(up_out_valid), .output_tdata(up_out_data),
    .output_tlast(up_out_last)
  );

  thresholding_lane_regroup #(.IN_PE(4), .OUT_PE(1), .ELEM_WIDTH(8), .CHANNELS(4)) u_dn (
    .clk(clk), .rst(rst),
    .input_tready(dn_in_ready), .input_tvalid(dn_in_valid), .input_tdata(dn_in_data),
    .output_tready(dn_out_ready), .output_tvalid(dn_out_valid), .output_tdata(dn_out_data),
    .output_tlast(dn_out_last)
  );

  thresholding_lane_regroup #(.IN_PE(3), .OUT_PE(1), .ELEM_WIDTH(3), .CHANNELS(3)) u_pd (
    .clk(clk), .rst(rst),
    .input_tready(pd_in_ready), .input_tvalid(pd_in_valid), .input_tdata(pd_in_data),
    .output_tready(pd_out_ready), .output_tvalid(pd_out_valid), .output_tdata(pd_out_data),
    .output_tlast(pd_out_last)
  );

  thresholding_lane_regroup #(.IN_PE(2), .OUT_PE(2), .ELEM_WIDTH(8), .CHANNELS(8)) u_ps (
    .clk(clk), .rst(rst),
    .input_tready(ps_in_ready), .input_tvalid(ps_in_valid), .input_tdata(ps_in_data),
    .output_tready(ps_out_ready), .output_tvalid(ps_out_valid), .output_tdata(ps_out_data),
    .output_tlast(ps_out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int fbOf(input int inst);
    case (inst)
      0:       fbOf = 2;
      1:       fbOf = 4;
      2:       fbOf = 3;
      default: fbOf = 4;
    endcase
  endfunction

  function automatic logic readyOf(input int inst);
    case (inst)
      0:       readyOf = up_in_ready;
      1:       readyOf = dn_in_ready;
      2:       readyOf = pd_in_ready;
      default: readyOf = ps_in_ready;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportExtra(input string name, input logic [31:0] actual);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=0x%0h required=no_beat", name, actual);
  endtask

  task automatic pushExp(input int inst, input logic [31:0] data);
    exp_t e;
    e.data = data;
    e.last = TLAST_ON && ((push_cnt[inst] % fbOf(inst)) == (fbOf(inst) - 1));
    push_cnt[inst]++;
    case (inst)
      0:       q_up.push_back(e);
      1:       q_dn.push_back(e);
      2:       q_pd.push_back(e);
      default: q_ps.push_back(e);
    endcase
  endtask

  // Drives one beat and returns how many cycles it waited for input_tready.
  task automatic applyStimulus(input int inst, input logic [31:0] data, output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    case (inst)
      0:       begin up_in_valid = 1'b1; up_in_data = data[7:0];  end
      1:       begin dn_in_valid = 1'b1; dn_in_data = data;       end
      2:       begin pd_in_valid = 1'b1; pd_in_data = data[15:0]; end
      default: begin ps_in_valid = 1'b1; ps_in_data = data[15:0]; end
    endcase
    while (!done && waited < 40) begin
      @(negedge clk);
      done = readyOf(inst);
      @(posedge clk);
      #1;
      if (!done) waited++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout lane=%0d actual=stalled required=accepted", inst);
    end
    up_in_valid = 1'b0;
    dn_in_valid = 1'b0;
    pd_in_valid = 1'b0;
    ps_in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && up_out_valid && up_out_ready) begin
      if (q_up.size() == 0) reportExtra("up_extra", 32'(up_out_data));
      else begin
        e = q_up.pop_front();
        checkOutput("up_data", 32'(up_out_data), e.data);
        checkOutput("up_last", 32'(up_out_last), 32'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && dn_out_valid && dn_out_ready) begin
      if (q_dn.size() == 0) reportExtra("dn_extra", 32'(dn_out_data));
      else begin
        e = q_dn.pop_front();
        checkOutput("dn_data", 32'(dn_out_data), e.data);
        checkOutput("dn_last", 32'(dn_out_last), 32'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && pd_out_valid && pd_out_ready) begin
      if (q_pd.size() == 0) reportExtra("pd_extra", 32'(pd_out_data));
      else begin
        e = q_pd.pop_front();
        checkOutput("pd_data", 32'(pd_out_data), e.data);
        checkOutput("pd_last", 32'(pd_out_last), 32'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ps_out_valid && ps_out_ready) begin
      if (q_ps.size() == 0) reportExtra("ps_extra", 32'(ps_out_data));
      else begin
        e = q_ps.pop_front();
        checkOutput("ps_data", 32'(ps_out_data), e.data);
        checkOutput("ps_last", 32'(ps_out_last), 32'(e.last));
      end
    end
  end

  initial begin
    int w;
    int left;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4; i++) push_cnt[i] = 0;
    rst = 1'b1;
    up_in_valid = 1'b0; dn_in_valid = 1'b0; pd_in_valid = 1'b0; ps_in_valid = 1'b0;
    up_in_data = '0; dn_in_data = '0; pd_in_data = '0; ps_in_data = '0;
    up_out_ready = 1'b1; dn_out_ready = 1'b1; pd_out_ready = 1'b1; ps_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_up_in_ready", 32'(up_in_ready), 32'd0);
    checkOutput("rst_dn_in_ready", 32'(dn_in_ready), 32'd0);
    checkOutput("rst_ps_in_ready", 32'(ps_in_ready), 32'd0);
    checkOutput("rst_up_valid", 32'(up_out_valid), 32'd0);
    checkOutput("rst_up_data", 32'(up_out_data), 32'd0);
    checkOutput("rst_dn_valid", 32'(dn_out_valid), 32'd0);
    checkOutput("rst_pd_data", 32'(pd_out_data), 32'd0);
    checkOutput("rst_ps_last", 32'(ps_out_last), 32'd0);
    rst = 1'b0;

    // Up mode with a ready sink, two groups back to back
    pushExp(0, 32'h4321);
    applyStimulus(0, 32'h21, w);
    checkOutput("up_stall_a", w, 32'd0);
    checkOutput("up_valid_early", 32'(up_out_valid), 32'd0);
    applyStimulus(0, 32'h43, w);
    checkOutput("up_stall_b", w, 32'd0);
    checkOutput("up_valid_next", 32'(up_out_valid), 32'd1);
    pushExp(0, 32'h8765);
    applyStimulus(0, 32'h65, w);
    checkOutput("up_stall_c", w, 32'd0);
    applyStimulus(0, 32'h87, w);
    checkOutput("up_stall_d", w, 32'd0);

    // Down mode: ready only during the last slice
    pushExp(1, 32'hAA); pushExp(1, 32'hBB); pushExp(1, 32'hCC); pushExp(1, 32'hDD);
    applyStimulus(1, 32'hDDCCBBAA, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("dn_in_ready_slice", 32'(dn_in_ready), (i == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;

    // Up mode backpressure: group held while the next one fills up to k=1
    up_out_ready = 1'b0;
    pushExp(0, 32'h4321);
    pushExp(0, 32'h8765);
    applyStimulus(0, 32'h21, w);
    applyStimulus(0, 32'h43, w);
    applyStimulus(0, 32'h65, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("up_hold_data", 32'(up_out_data), 32'h4321);
      checkOutput("up_hold_valid", 32'(up_out_valid), 32'd1);
      checkOutput("up_in_ready_k1", 32'(up_in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    up_out_ready = 1'b1;
    applyStimulus(0, 32'h87, w);
    checkOutput("up_resume_stall", w, 32'd0);

    // Reset in the middle of a down-mode word
    pushExp(1, 32'h11); pushExp(1, 32'h22);
    applyStimulus(1, 32'h44332211, w);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("dn_midrst_valid", 32'(dn_out_valid), 32'd0);
    checkOutput("dn_midrst_data", 32'(dn_out_data), 32'd0);
    checkOutput("dn_midrst_ready", 32'(dn_in_ready), 32'd0);
    for (int i = 0; i < 4; i++) push_cnt[i] = 0;
    rst = 1'b0;
    pushExp(1, 32'h01); pushExp(1, 32'h02); pushExp(1, 32'h03); pushExp(1, 32'h04);
    applyStimulus(1, 32'h04030201, w);

    // Padding: 9-bit payload in a 16-bit input, 3-bit lanes in an 8-bit output
    pushExp(2, 32'h5); pushExp(2, 32'h2); pushExp(2, 32'h7);
    applyStimulus(2, 32'hFFD5, w);
    pushExp(2, 32'h0); pushExp(2, 32'h7); pushExp(2, 32'h1);
    applyStimulus(2, 32'h0078, w);
    pushExp(2, 32'h3); pushExp(2, 32'h4); pushExp(2, 32'h6);
    applyStimulus(2, 32'hFFA3, w);

    // Pass-through, two frames of four beats for the frame marker
    for (int i = 0; i < 8; i++) begin
      pushExp(3, 32'hA0B0 + i);
      applyStimulus(3, 32'hA0B0 + i, w);
      checkOutput("ps_stall", w, 32'd0);
      if (i == 0) checkOutput("ps_latency", 32'(ps_out_valid), 32'd1);
    end

    left = 100;
    while (left > 0 && (q_up.size() + q_dn.size() + q_pd.size() + q_ps.size()) != 0) begin
      @(negedge clk);
      left--;
    end
    @(posedge clk);
    #1;
    checkOutput("queues_empty", 32'(q_up.size() + q_dn.size() + q_pd.size() + q_ps.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
